// File: rtl/dtw_pkg.sv
// Shared DTW result-frame constants: collector FSM encoding and the word order the core serialises frames in.
package dtw_pkg;

    localparam int FRAME_WORDS = 3;
    localparam int WIDX_W      = 2;

    typedef logic [WIDX_W-1:0] widx_t;

    localparam widx_t WORD_QID    = 2'd0;
    localparam widx_t WORD_POS    = 2'd1;
    localparam widx_t WORD_MINVAL = widx_t'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/dtw_result_collector_if.sv
// Result record bus from the collector to the AXI-side status logic (valid/ready, fields held while valid).
interface dtw_result_collector_if #(
    parameter int axi_dwidth = 32,
    parameter int dtw_dwidth = 16
);
    logic                  res_valid;
    logic                  res_ready;
    logic [axi_dwidth-1:0] res_qid;
    logic [axi_dwidth-1:0] res_position;
    logic [dtw_dwidth-1:0] res_minval;
    logic                  res_match;

    modport master (
        output res_valid, res_qid, res_position, res_minval, res_match,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_qid, res_position, res_minval, res_match,
        output res_ready
    );
endinterface

// File: rtl/dtw_stat_counter.sv
// Wrapping event counter, 1-cycle update; a clear in the same cycle as an increment wins.
module dtw_stat_counter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [width-1:0] count_o
);

    logic [width-1:0] cnt_q;
    logic [width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/dtw_result_collector.sv
// Pops 3-word result frames from the sink FIFO (2 cycles/word) and presents one record; holds it in OUT
// until res_ready, never reading the FIFO meanwhile. Counts accepted records/matches, flags bad minval words.
module dtw_result_collector
    import dtw_pkg::*;
#(
    parameter int axi_dwidth = 32,
    parameter int dtw_dwidth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [dtw_dwidth-1:0] threshold,
    input  logic                  clear_counts,
    output logic                  sink_fifo_rden,
    input  logic                  sink_fifo_empty,
    input  logic [axi_dwidth-1:0] sink_fifo_data,
    dtw_result_collector_if.master res_if,
    output logic [axi_dwidth-1:0] result_count,
    output logic [axi_dwidth-1:0] match_count,
    output logic                  frame_err
);

    state_t                state_q, state_d;
    widx_t                 widx_q, widx_d;
    logic [axi_dwidth-1:0] qid_q, qid_d;
    logic [axi_dwidth-1:0] pos_q, pos_d;
    logic [dtw_dwidth-1:0] minval_q, minval_d;
    logic                  match_q, match_d;
    logic                  err_q, err_d;
    logic                  hs;

    assign hs = (state_q == OUT) && res_if.res_ready;

    always_comb begin
        state_d        = state_q;
        widx_d         = widx_q;
        qid_d          = qid_q;
        pos_d          = pos_q;
        minval_d       = minval_q;
        match_d        = match_q;
        err_d          = err_q;
        sink_fifo_rden = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && !sink_fifo_empty) begin
                    state_d = REQ;
                    widx_d  = WORD_QID;
                end
            end
            REQ: begin
                if (!sink_fifo_empty) begin
                    sink_fifo_rden = 1'b1;
                    state_d        = CAP;
                end
            end
            CAP: begin
                case (widx_q)
                    WORD_QID: qid_d = sink_fifo_data;
                    WORD_POS: pos_d = sink_fifo_data;
                    default: begin
                        minval_d = sink_fifo_data[dtw_dwidth-1:0];
                        match_d  = sink_fifo_data[dtw_dwidth-1:0] < threshold;
                        // Upper half must be zero padding; a non-zero value means the frame slipped.
                        if (sink_fifo_data[axi_dwidth-1:dtw_dwidth] != '0) begin
                            err_d = 1'b1;
                        end
                    end
                endcase
                if (widx_q == WORD_MINVAL) begin
                    state_d = OUT;
                end else begin
                    widx_d  = widx_q + widx_t'(1);
                    state_d = REQ;
                end
            end
            OUT: begin
                if (hs) begin
                    state_d = IDLE;
                    widx_d  = WORD_QID;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            widx_q   <= WORD_QID;
            qid_q    <= '0;
            pos_q    <= '0;
            minval_q <= '0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            widx_q   <= widx_d;
            qid_q    <= qid_d;
            pos_q    <= pos_d;
            minval_q <= minval_d;
            match_q  <= match_d;
            err_q    <= err_d;
        end
    end

    assign res_if.res_valid    = (state_q == OUT);
    assign res_if.res_qid      = qid_q;
    assign res_if.res_position = pos_q;
    assign res_if.res_minval   = minval_q;
    assign res_if.res_match    = match_q;
    assign frame_err           = err_q;

    dtw_stat_counter #(.width(axi_dwidth)) u_result_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear_counts),
        .inc_i   (hs),
        .count_o (result_count)
    );

    dtw_stat_counter #(.width(axi_dwidth)) u_match_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear_counts),
        .inc_i   (hs && match_q),
        .count_o (match_count)
    );

endmodule

// File: tb/tb_dtw_result_collector.sv
// Bench for dtw_result_collector: behavioural sink FIFO, frame-level reference model, directed and random frames.
module tb_dtw_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        clear_counts = 1'b0;
    logic [15:0] threshold = 16'h0;
    logic        sink_fifo_rden;
    logic        sink_fifo_empty;
    logic [31:0] sink_fifo_data = 32'h0;
    logic [31:0] result_count;
    logic [31:0] match_count;
    logic        frame_err;

    dtw_result_collector_if #(.axi_dwidth(32), .dtw_dwidth(16)) res_if ();

    dtw_result_collector #(.axi_dwidth(32), .dtw_dwidth(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .threshold       (threshold),
        .clear_counts    (clear_counts),
        .sink_fifo_rden  (sink_fifo_rden),
        .sink_fifo_empty (sink_fifo_empty),
        .sink_fifo_data  (sink_fifo_data),
        .res_if          (res_if.master),
        .result_count    (result_count),
        .match_count     (match_count),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    // Sink FIFO model: data appears the cycle after a rden issued while non-empty; reset flushes it.
    logic [31:0] fifo_mem [0:63];
    int          push_cnt = 0;
    int          pop_cnt  = 0;

    assign sink_fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_cnt <= push_cnt;
        end else if (sink_fifo_rden && !sink_fifo_empty) begin
            sink_fifo_data <= fifo_mem[pop_cnt % 64];
            pop_cnt        <= pop_cnt + 1;
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_rc = 32'h0;
    logic [31:0] m_mc = 32'h0;
    logic        m_err = 1'b0;
    logic [80:0] got;
    logic [80:0] exp_rec;

    assign got = {res_if.res_qid, res_if.res_position, res_if.res_minval, res_if.res_match};

    function automatic logic [80:0] model_rec(input logic [31:0] q, input logic [31:0] p,
                                              input logic [31:0] m, input logic [15:0] thr);
        return {q, p, m[15:0], (m[15:0] < thr)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[push_cnt % 64] = w;
        push_cnt++;
    endtask

    task automatic push_frame(input logic [31:0] q, input logic [31:0] p, input logic [31:0] m);
        push(q);
        push(p);
        push(m);
    endtask

    task automatic wait_valid(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (res_if.res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_valid: res_valid=%b after %0d cycles, required 1", res_if.res_valid, budget);
        end
    endtask

    task automatic handshake(input logic [31:0] m, input logic [15:0] thr);
        res_if.res_ready = 1'b1;
        tick();
        res_if.res_ready = 1'b0;
        m_rc = m_rc + 1;
        if (m[15:0] < thr) m_mc = m_mc + 1;
        if (m[31:16] != 16'h0) m_err = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        checks++;
        if ({sink_fifo_rden, res_if.res_valid} !== 2'b00) begin
            failures++; $display("FAIL reset_ctl: got %b required 00", {sink_fifo_rden, res_if.res_valid});
        end
        checks++;
        if (got !== 81'h0) begin
            failures++; $display("FAIL reset_fields: got %h required 0", got);
        end
        checks++;
        if ({result_count, match_count} !== 64'h0) begin
            failures++; $display("FAIL reset_counts: got %h/%h required 0/0", result_count, match_count);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            failures++; $display("FAIL reset_err: got %b required 0", frame_err);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        logic [7:0] rden_seen;
        logic [7:0] vld_seen;
        rden_seen = 8'h0;
        vld_seen  = 8'h0;
        threshold = 16'h0060;
        res_if.res_ready = 1'b1;
        push_frame(32'h7, 32'h1234, 32'h50);
        enable = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            rden_seen[k] = sink_fifo_rden;
            vld_seen[k]  = res_if.res_valid;
        end
        checks++;
        if (rden_seen !== 8'b0010_1010) begin
            failures++; $display("FAIL lat_rden: got %b required 00101010", rden_seen);
        end
        checks++;
        if (vld_seen !== 8'b1000_0000) begin
            failures++; $display("FAIL lat_valid: got %b required 10000000", vld_seen);
        end
        exp_rec = model_rec(32'h7, 32'h1234, 32'h50, 16'h0060);
        checks++;
        if (got !== exp_rec) begin
            failures++; $display("FAIL lat_record: got %h required %h", got, exp_rec);
        end
        tick();
        res_if.res_ready = 1'b0;
        m_rc = m_rc + 1;
        m_mc = m_mc + 1;
        checks++;
        if ({res_if.res_valid, result_count, match_count} !== {1'b0, m_rc, m_mc}) begin
            failures++; $display("FAIL lat_counts: got v=%b %0d/%0d required v=0 %0d/%0d",
                                 res_if.res_valid, result_count, match_count, m_rc, m_mc);
        end
    endtask

    task automatic test_no_match();
        threshold = 16'h0050;
        push_frame(32'h7, 32'h1234, 32'h50);
        wait_valid(40);
        exp_rec = model_rec(32'h7, 32'h1234, 32'h50, 16'h0050);
        checks++;
        if (got !== exp_rec) begin
            failures++; $display("FAIL nomatch_record: got %h required %h", got, exp_rec);
        end
        handshake(32'h50, 16'h0050);
        checks++;
        if ({result_count, match_count} !== {m_rc, m_mc}) begin
            failures++; $display("FAIL nomatch_counts: got %0d/%0d required %0d/%0d",
                                 result_count, match_count, m_rc, m_mc);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        int base_pop;
        bad = 0;
        threshold = 16'h0060;
        push_frame(32'hA1, 32'h100, 32'h30);
        push_frame(32'hB2, 32'h200, 32'h70);
        wait_valid(40);
        exp_rec  = model_rec(32'hA1, 32'h100, 32'h30, 16'h0060);
        base_pop = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_if.res_valid !== 1'b1 || got !== exp_rec || sink_fifo_rden !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || pop_cnt != base_pop) begin
            failures++; $display("FAIL bp_hold: got %0d unstable cycles, %0d pops required 0, 0",
                                 bad, pop_cnt - base_pop);
        end
        handshake(32'h30, 16'h0060);
        wait_valid(40);
        exp_rec = model_rec(32'hB2, 32'h200, 32'h70, 16'h0060);
        checks++;
        if (got !== exp_rec) begin
            failures++; $display("FAIL bp_second: got %h required %h", got, exp_rec);
        end
        handshake(32'h70, 16'h0060);
    endtask

    task automatic test_empty_gap();
        int bad;
        bad = 0;
        threshold = 16'h0060;
        push(32'hC3);
        push(32'h3333);
        for (int i = 0; i < 20 && pop_cnt != push_cnt; i++) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (sink_fifo_rden !== 1'b0 || res_if.res_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL gap_idle: got %0d active cycles required 0", bad);
        end
        push(32'h20);
        wait_valid(40);
        exp_rec = model_rec(32'hC3, 32'h3333, 32'h20, 16'h0060);
        checks++;
        if (got !== exp_rec || pop_cnt != push_cnt) begin
            failures++; $display("FAIL gap_record: got %h pops=%0d required %h pops=%0d",
                                 got, pop_cnt, exp_rec, push_cnt);
        end
        handshake(32'h20, 16'h0060);
    endtask

    task automatic test_frame_err();
        threshold = 16'h0060;
        push_frame(32'h11, 32'h22, 32'h0001_0050);
        wait_valid(40);
        exp_rec = model_rec(32'h11, 32'h22, 32'h0001_0050, 16'h0060);
        checks++;
        if ({frame_err, got} !== {1'b1, exp_rec}) begin
            failures++; $display("FAIL err_record: got err=%b %h required err=1 %h", frame_err, got, exp_rec);
        end
        handshake(32'h0001_0050, 16'h0060);
        push_frame(32'h12, 32'h23, 32'h40);
        wait_valid(40);
        exp_rec = model_rec(32'h12, 32'h23, 32'h40, 16'h0060);
        checks++;
        if ({frame_err, got} !== {m_err, exp_rec}) begin
            failures++; $display("FAIL err_sticky: got err=%b %h required err=%b %h", frame_err, got, m_err, exp_rec);
        end
        handshake(32'h40, 16'h0060);
    endtask

    task automatic test_enable_midframe();
        int base_pop;
        threshold = 16'h0100;
        push(32'hE1);
        tick();
        tick();
        enable = 1'b0;
        push(32'hE2);
        push(32'h00FF);
        wait_valid(40);
        exp_rec = model_rec(32'hE1, 32'hE2, 32'h00FF, 16'h0100);
        checks++;
        if (got !== exp_rec) begin
            failures++; $display("FAIL en_midframe: got %h required %h", got, exp_rec);
        end
        handshake(32'h00FF, 16'h0100);
        base_pop = pop_cnt;
        push_frame(32'hF1, 32'hF2, 32'h0100);
        repeat (10) tick();
        checks++;
        if (pop_cnt != base_pop || res_if.res_valid !== 1'b0) begin
            failures++; $display("FAIL en_off_idle: got %0d pops valid=%b required 0 pops valid=0",
                                 pop_cnt - base_pop, res_if.res_valid);
        end
        enable = 1'b1;
        wait_valid(40);
        exp_rec = model_rec(32'hF1, 32'hF2, 32'h0100, 16'h0100);
        checks++;
        if (got !== exp_rec) begin
            failures++; $display("FAIL en_resume: got %h required %h", got, exp_rec);
        end
        handshake(32'h0100, 16'h0100);
    endtask

    task automatic test_clear_on_hs();
        threshold = 16'h0060;
        push_frame(32'h31, 32'h32, 32'h10);
        wait_valid(40);
        clear_counts = 1'b1;
        handshake(32'h10, 16'h0060);
        clear_counts = 1'b0;
        m_rc = 32'h0;
        m_mc = 32'h0;
        checks++;
        if ({result_count, match_count} !== {m_rc, m_mc}) begin
            failures++; $display("FAIL clear_wins: got %0d/%0d required 0/0", result_count, match_count);
        end
    endtask

    task automatic test_mid_reset();
        int base_pop;
        threshold = 16'h0060;
        base_pop = pop_cnt;
        push_frame(32'h55, 32'h66, 32'h10);
        for (int i = 0; i < 20 && pop_cnt - base_pop < 2; i++) tick();
        tick();
        rst = 1'b0;
        #1;
        m_rc = 32'h0;
        m_mc = 32'h0;
        m_err = 1'b0;
        checks++;
        if ({sink_fifo_rden, res_if.res_valid, got, result_count, match_count, frame_err} !== 148'h0) begin
            failures++; $display("FAIL midrst_zero: got rden=%b v=%b rec=%h cnt=%0d/%0d err=%b required all 0",
                                 sink_fifo_rden, res_if.res_valid, got, result_count, match_count, frame_err);
        end
        tick();
        rst = 1'b1;
        tick();
        push_frame(32'h77, 32'h88, 32'h99);
        wait_valid(40);
        exp_rec = model_rec(32'h77, 32'h88, 32'h99, 16'h0060);
        checks++;
        if (got !== exp_rec) begin
            failures++; $display("FAIL midrst_realign: got %h required %h", got, exp_rec);
        end
        handshake(32'h99, 16'h0060);
    endtask

    task automatic test_random();
        logic [31:0] q;
        logic [31:0] p;
        logic [31:0] m;
        logic [15:0] thr;
        int          bad;
        for (int f = 0; f < 24; f++) begin
            thr = 16'($urandom);
            q   = $urandom;
            p   = $urandom;
            m   = {(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0), 16'($urandom)};
            if (f % 5 == 0) m[15:0] = thr;
            threshold = thr;
            for (int w = 0; w < 3; w++) begin
                repeat ($urandom_range(0, 2)) tick();
                push((w == 0) ? q : (w == 1) ? p : m);
            end
            wait_valid(60);
            exp_rec = model_rec(q, p, m, thr);
            bad = 0;
            threshold = ~thr;
            repeat ($urandom_range(0, 3)) begin
                tick();
                if (got !== exp_rec || res_if.res_valid !== 1'b1) bad++;
            end
            checks++;
            if (got !== exp_rec || bad != 0) begin
                failures++; $display("FAIL rand_record[%0d]: got %h (%0d unstable) required %h", f, got, bad, exp_rec);
            end
            handshake(m, thr);
        end
        checks++;
        if ({result_count, match_count, frame_err} !== {m_rc, m_mc, m_err}) begin
            failures++; $display("FAIL rand_totals: got %0d/%0d err=%b required %0d/%0d err=%b",
                                 result_count, match_count, frame_err, m_rc, m_mc, m_err);
        end
    endtask

    initial begin
        res_if.res_ready = 1'b0;
        test_reset();
        test_latency();
        test_no_match();
        test_backpressure();
        test_empty_gap();
        test_frame_err();
        test_enable_midframe();
        test_clear_on_hs();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dtw_result_collector.md
Name: dtw_result_collector

Overview:
Reader for the DTW core's sink FIFO, which the core fills with 3-word result frames in the order query id, best position, {16'b0, minval}. The collector pops each frame one word at a time and reassembles it into one parallel result record. It classifies the record against a programmable threshold and presents it on a valid/ready interface to the AXI-side status logic. It also keeps result and match counters and a sticky framing-error flag.

Parameters:
axi_dwidth, 32, width of FIFO words, qid, position and the counters.
dtw_dwidth, 16, width of minval and threshold.
FRAME_WORDS, 3, words per result frame. Fixed protocol constant; not to be overridden.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
enable  in  1  allows a new frame to start.
threshold  in  dtw_dwidth  match threshold, unsigned.
clear_counts  in  1  synchronous clear of both counters.
sink_fifo_rden  out  1  read enable to the sink FIFO.
sink_fifo_empty  in  1  FIFO empty flag.
sink_fifo_data  in  axi_dwidth  FIFO read data; valid the cycle after a rden that was issued while the FIFO was not empty.
res_valid  out  1  result record valid.
res_ready  in  1  downstream accepts the record.
res_qid  out  axi_dwidth  query id.
res_position  out  axi_dwidth  best reference position.
res_minval  out  dtw_dwidth  minimum DTW cost.
res_match  out  1  1 when res_minval < threshold.
result_count  out  axi_dwidth  number of accepted records.
match_count  out  axi_dwidth  number of accepted records with res_match = 1.
frame_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, word_idx = 0.
  - All outputs are 0: sink_fifo_rden, res_valid, res_qid, res_position, res_minval, res_match, result_count, match_count, frame_err.
- States:
  - IDLE: if enable = 1 and sink_fifo_empty = 0, go to REQ with word_idx = 0; otherwise stay.
  - REQ: sink_fifo_rden = (state == REQ) && !sink_fifo_empty, decoded combinationally. It is high for exactly one cycle per word. If empty, stay in REQ with rden = 0; there is no timeout. If rden is issued, go to CAP.
  - CAP: capture sink_fifo_data into the field selected by word_idx: 0 → qid, 1 → position, 2 → minval.
    - If word_idx < 2: increment word_idx and return to REQ.
    - If word_idx == 2: sample threshold, register res_match = (data[15:0] < threshold), go to OUT.
  - OUT: res_valid = 1, and all res_* outputs are held stable. On res_valid && res_ready, drop res_valid, reset word_idx to 0, and go to IDLE. The FIFO is never read while in OUT.
- Latency:
  - One word takes 2 cycles (REQ, CAP) when the FIFO is not empty.
  - With a full frame already present, rden is high at cycles 1, 3 and 5 after leaving IDLE, and res_valid rises at cycle 7.
  - Minimum back-to-back frame period is 8 cycles when res_ready is held at 1.
- Enable:
  - enable is only sampled in IDLE.
  - Deasserting enable mid-frame does not abort the frame. The current frame completes so the 3-word alignment is preserved.
- Framing check:
  - If the minval word has data[31:16] != 0, frame_err is set sticky.
  - The lower 16 bits are still used and the record is still delivered.
  - frame_err is cleared only by reset.
- Counters:
  - On a handshake, result_count += 1; match_count += 1 when res_match = 1.
  - Both counters wrap modulo 2^axi_dwidth.
  - If clear_counts and a handshake occur in the same cycle, clear wins and both counters become 0.
- Reset asserted mid-frame:
  - Partial fields are discarded and word_idx returns to 0.
  - Realignment with the FIFO after a mid-frame reset is the system's responsibility; the FIFO is reset alongside this block.
- Comparison is unsigned and strict: minval == threshold gives no match.

Decomposition:
- Shared package dtw_pkg holds:
  - state encoding (IDLE = 0, REQ = 1, CAP = 2, OUT = 3);
  - word indices WORD_QID = 0, WORD_POS = 1, WORD_MINVAL = 2;
  - FRAME_WORDS = 3.
- These indices are the same ones the core uses to serialise frames.
- The FSM and capture logic form a single module.
- The two counters, with their clear/increment priority, go in one sub-module dtw_stat_counter, instantiated twice.

Test Plan:
- FIFO preloaded with 0x00000007, 0x00001234, 0x00000050; threshold = 0x0060; res_ready = 1 → rden at cycles 1/3/5; record qid = 7, position = 0x1234, minval = 0x50, res_match = 1; result_count = 1, match_count = 1.
- Same frame with threshold = 0x0050 → res_match = 0; match_count stays 0; result_count = 1.
- res_ready held at 0 for 10 cycles while a second frame sits in the FIFO → res_valid and fields stay stable; no rden; on release, the second frame is read afterwards.
- FIFO goes empty between word 1 and word 2 for 5 cycles → rden stays low; captured fields stay correct; no extra pop.
- Minval word = 0x00010050 → frame_err = 1 and stays set; res_minval = 0x0050; the next clean frame is delivered normally.
- clear_counts asserted in the same cycle as a handshake → both counters = 0. Then reset asserted mid-frame (after word 1) → all outputs 0; the next 3 pushed words form a correct record.
